// File: rtl/warp_imem_responder.sv
// Instruction-fetch responder: fixed-latency 64-bit reads from a local preloadable store,
// with an in-flight {valid, error} pipeline that can be flushed on a fetch redirect.
module warp_imem_responder #(
    parameter logic [38:0] BASE_ADDR   = 39'h4000000000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_imem_ren,
    input  logic [38:0]      i_imem_raddr,
    output logic             o_imem_valid,
    output logic [63:0]      o_imem_rdata,
    output logic             o_imem_error,
    input  logic             i_flush,
    input  logic             i_load_en,
    input  logic [IDX_W-1:0] i_load_idx,
    input  logic [63:0]      i_load_data,
    output logic             o_busy
);

    logic [38:0]      w_off;
    logic             w_in_range;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_en;
    logic             w_unused_off;
    logic             w_busy;

    logic [63:0]      r_mem    [DEPTH_WORDS];
    logic [63:0]      r_data_p [LATENCY];
    logic             r_err_p  [LATENCY];
    logic             r_vld_p  [LATENCY];

    // Byte offset bits [2:0] only pick a halfword, which the fetch unit handles.
    assign w_off        = i_imem_raddr - BASE_ADDR;
    assign w_in_range   = (i_imem_raddr >= BASE_ADDR) && (w_off[38:3] < 36'(DEPTH_WORDS));
    assign w_rd_idx     = w_off[IDX_W+2:3];
    assign w_rd_en      = i_imem_ren && w_in_range;
    assign w_unused_off = ^w_off[2:0];

    always_ff @(posedge i_clk) begin
        if (i_load_en) begin
            r_mem[i_load_idx] <= i_load_data;
        end
    end

    // p0: RAM read (read-before-write on a same-index load), later stages delay the word
    always_ff @(posedge i_clk) begin
        if (w_rd_en) begin
            r_data_p[0] <= r_mem[w_rd_idx];
        end
        r_err_p[0] <= !w_in_range;
        for (int k = 1; k < LATENCY; k++) begin
            r_data_p[k] <= r_data_p[k-1];
            r_err_p[k]  <= r_err_p[k-1];
        end
    end

    // Flush keeps the same-cycle request in p0; reset drops it as well.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_vld_p[k] <= 1'b0;
            end
        end else begin
            r_vld_p[0] <= i_imem_ren;
            for (int k = 1; k < LATENCY; k++) begin
                r_vld_p[k] <= i_flush ? 1'b0 : r_vld_p[k-1];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            w_busy = w_busy | r_vld_p[k];
        end
    end

    assign o_busy       = w_busy;
    assign o_imem_valid = r_vld_p[LATENCY-1];
    assign o_imem_error = r_vld_p[LATENCY-1] & r_err_p[LATENCY-1];
    assign o_imem_rdata = (r_vld_p[LATENCY-1] && !r_err_p[LATENCY-1]) ? r_data_p[LATENCY-1] : 64'h0;

endmodule

// File: tb/tb_warp_imem_responder.sv
// Bench for warp_imem_responder: LATENCY=2 and LATENCY=3 instances share stimulus and
// are checked every cycle against a queue-based response model plus directed literals.
module tb_warp_imem_responder;

    localparam logic [38:0] BASE  = 39'h4000000000;
    localparam int          DEPTH = 64;
    localparam int          IW    = 6;

    logic          clk = 1'b0;
    logic          rst, ren, flush, load_en;
    logic [38:0]   raddr;
    logic [IW-1:0] lidx;
    logic [63:0]   ldata;
    logic          v2, e2, b2, v3, e3, b3;
    logic [63:0]   d2, d3;

    always #5 clk = ~clk;

    warp_imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_imem_ren(ren), .i_imem_raddr(raddr),
        .o_imem_valid(v2), .o_imem_rdata(d2), .o_imem_error(e2), .i_flush(flush),
        .i_load_en(load_en), .i_load_idx(lidx), .i_load_data(ldata), .o_busy(b2)
    );

    warp_imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_imem_ren(ren), .i_imem_raddr(raddr),
        .o_imem_valid(v3), .o_imem_rdata(d3), .o_imem_error(e3), .i_flush(flush),
        .i_load_en(load_en), .i_load_idx(lidx), .i_load_data(ldata), .o_busy(b3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: store contents plus one queue of pending responses per latency,
    // each entry tagged with the edge count after which it is on the outputs.
    typedef struct {
        int          due;
        logic [63:0] d;
        logic        e;
    } rsp_t;

    logic [63:0] mmem [DEPTH];
    rsp_t        q2[$];
    rsp_t        q3[$];
    int          ecnt   = 0;
    bit          cmp_en = 0;

    always @(posedge clk) begin : p_model
        logic [38:0] off;
        logic        inr;
        logic [63:0] rd;
        rsp_t        r;
        ecnt++;
        while (q2.size() > 0 && q2[0].due < ecnt) void'(q2.pop_front());
        while (q3.size() > 0 && q3[0].due < ecnt) void'(q3.pop_front());
        if (rst || flush) begin
            q2.delete();
            q3.delete();
        end
        off = raddr - BASE;
        inr = (raddr >= BASE) && ((off >> 3) < 39'(DEPTH));
        rd  = inr ? mmem[off[IW+2:3]] : 64'h0;
        if (!rst && ren) begin
            r.d = rd;
            r.e = !inr;
            r.due = ecnt + 1;
            q2.push_back(r);
            r.due = ecnt + 2;
            q3.push_back(r);
        end
        if (load_en) mmem[lidx] = ldata;
        if (rst) cmp_en = 1;
    end

    always @(negedge clk) begin : p_compare
        if (cmp_en) begin
            if (q2.size() > 0 && q2[0].due == ecnt) begin
                chk("valid2", 64'(v2), 64'd1);
                chk("rdata2", d2, q2[0].d);
                chk("error2", 64'(e2), 64'(q2[0].e));
            end else begin
                chk("valid2", 64'(v2), 64'd0);
                chk("rdata2", d2, 64'd0);
                chk("error2", 64'(e2), 64'd0);
            end
            chk("busy2", 64'(b2), 64'(q2.size() > 0));
            if (q3.size() > 0 && q3[0].due == ecnt) begin
                chk("valid3", 64'(v3), 64'd1);
                chk("rdata3", d3, q3[0].d);
                chk("error3", 64'(e3), 64'(q3[0].e));
            end else begin
                chk("valid3", 64'(v3), 64'd0);
                chk("rdata3", d3, 64'd0);
                chk("error3", 64'(e3), 64'd0);
            end
            chk("busy3", 64'(b3), 64'(q3.size() > 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int idx, input logic [63:0] data);
        load_en = 1'b1;
        lidx    = IW'(idx);
        ldata   = data;
        cyc();
        load_en = 1'b0;
    endtask

    initial begin
        logic [38:0] ca [3];
        int          sel;
        rst = 1'b1; ren = 1'b0; flush = 1'b0; load_en = 1'b0;
        raddr = BASE; lidx = '0; ldata = '0;
        cyc();
        cyc();
        chk("reset_valid2", 64'(v2), 64'd0);
        chk("reset_busy3", 64'(b3), 64'd0);
        chk("reset_rdata3", d3, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) load(i, {$urandom, $urandom});

        // Latency / throughput
        for (int i = 0; i < 4; i++) load(i, 64'hA0 + 64'(i));
        for (int i = 0; i < 7; i++) begin
            ren   = (i < 4);
            raddr = BASE + 39'(8 * i);
            cyc();
            chk("A_valid2", 64'(v2), (i >= 1 && i <= 4) ? 64'd1 : 64'd0);
            chk("A_rdata2", d2, (i >= 1 && i <= 4) ? 64'hA0 + 64'(i - 1) : 64'd0);
            chk("A_error2", 64'(e2), 64'd0);
        end
        ren = 1'b0;

        // Alignment
        load(0, 64'h1122334455667788);
        ren = 1'b1; raddr = BASE + 39'd6;
        cyc();
        ren = 1'b0;
        cyc();
        chk("B_valid2", 64'(v2), 64'd1);
        chk("B_rdata2", d2, 64'h1122334455667788);
        cyc();
        chk("B_rdata3", d3, 64'h1122334455667788);

        // Range check
        load(63, 64'hCAFEF00D0000003F);
        ca[0] = BASE - 39'd8;
        ca[1] = BASE + 39'(8 * DEPTH);
        ca[2] = BASE + 39'(8 * (DEPTH - 1));
        for (int i = 0; i < 5; i++) begin
            ren   = (i < 3);
            raddr = ca[i % 3];
            cyc();
            if (i >= 1 && i <= 3) begin
                chk("C_valid2", 64'(v2), 64'd1);
                chk("C_error2", 64'(e2), (i < 3) ? 64'd1 : 64'd0);
                chk("C_rdata2", d2, (i < 3) ? 64'd0 : 64'hCAFEF00D0000003F);
            end
        end
        ren = 1'b0;

        // Flush on the LATENCY=3 instance
        for (int i = 0; i < 4; i++) load(10 + i, 64'hD10 + 64'(i));
        for (int i = 0; i < 7; i++) begin
            ren   = (i <= 3);
            flush = (i == 3);
            raddr = BASE + 39'(8 * (10 + i));
            cyc();
            if (i == 2) begin
                chk("D_valid3_req0", 64'(v3), 64'd1);
                chk("D_rdata3_req0", d3, 64'hD10);
            end
            if (i == 3 || i == 4) begin
                chk("D_valid3_flushed", 64'(v3), 64'd0);
                chk("D_busy3_req3", 64'(b3), 64'd1);
            end
            if (i == 5) begin
                chk("D_valid3_req3", 64'(v3), 64'd1);
                chk("D_rdata3_req3", d3, 64'hD13);
            end
            if (i == 6) chk("D_busy3_idle", 64'(b3), 64'd0);
        end
        ren = 1'b0; flush = 1'b0;

        // Load/read collision
        load(5, 64'h5555);
        load_en = 1'b1; lidx = IW'(5); ldata = 64'hBEEF;
        ren = 1'b1; raddr = BASE + 39'd40;
        cyc();
        load_en = 1'b0;
        cyc();
        chk("E_old_rdata2", d2, 64'h5555);
        ren = 1'b0;
        cyc();
        chk("E_new_rdata2", d2, 64'hBEEF);

        // Reset mid-stream
        ren = 1'b1; raddr = BASE + 39'(8 * 10);
        cyc();
        raddr = BASE + 39'(8 * 11);
        cyc();
        chk("F_busy3_inflight", 64'(b3), 64'd1);
        rst = 1'b1; raddr = BASE + 39'(8 * 12);
        cyc();
        rst = 1'b0; ren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("F_valid2", 64'(v2), 64'd0);
            chk("F_valid3", 64'(v3), 64'd0);
            chk("F_busy2", 64'(b2), 64'd0);
            chk("F_busy3", 64'(b3), 64'd0);
            cyc();
        end
        ren = 1'b1; raddr = BASE + 39'(8 * 10);
        cyc();
        ren = 1'b0;
        cyc();
        chk("F_postreset_valid2", 64'(v2), 64'd1);
        chk("F_postreset_rdata2", d2, 64'hD10);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ren = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)
                raddr = BASE + 39'($urandom_range(0, DEPTH - 1)) * 39'd8 + 39'($urandom_range(0, 7));
            else if (sel == 7)
                raddr = BASE - 39'(8 * $urandom_range(1, 4));
            else if (sel == 8)
                raddr = BASE + 39'(8 * (DEPTH + $urandom_range(0, 3))) + 39'($urandom_range(0, 7));
            else
                raddr = 39'({$urandom, $urandom});
            flush   = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            load_en = ($urandom_range(0, 2) == 0);
            lidx    = IW'($urandom_range(0, DEPTH - 1));
            if (sel < 7 && $urandom_range(0, 3) == 0) lidx = raddr[IW+2:3];
            ldata   = {$urandom, $urandom};
            cyc();
        end
        ren = 1'b0; flush = 1'b0; rst = 1'b0; load_en = 1'b0;
        repeat (5) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_imem_responder.md
# warp_imem_responder

Responder end of the hart instruction-fetch interface: accepts read requests (`ren`/`raddr`) from the fetch unit and returns 64-bit instruction words (`valid`/`rdata`) after a fixed, parameterised latency. Sits between the hart's imem port and a local on-chip instruction store. It replaces the bench-side harness until the cache/AHB path exists. A side load port preloads the store, and a flush input discards in-flight responses on a fetch redirect.

## Interface
Parameters:
- `BASE_ADDR`, 39'h4000000000, byte address of store word 0; must be 8-byte aligned.
- `DEPTH_WORDS`, 4096, number of 64-bit words in the store; must be a power of two, 2..65536.
- `LATENCY`, 2, cycles from request sample to response; legal range 1..4.
- `IDX_W`, $clog2(DEPTH_WORDS), derived word-index width.

Ports:
- `i_clk` in 1: clock; all logic is on the rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_imem_ren` in 1: read request; the request is sampled on every edge where this is high.
- `i_imem_raddr` in 39: byte address of the request.
- `o_imem_valid` out 1: response valid, a single-cycle pulse per response.
- `o_imem_rdata` out 64: the aligned 64-bit word containing `raddr`.
- `o_imem_error` out 1: the request was out of range; qualified by `o_imem_valid`.
- `i_flush` in 1: drop all in-flight responses.
- `i_load_en` in 1: store write enable.
- `i_load_idx` in IDX_W: word index for the store write.
- `i_load_data` in 64: data for the store write.
- `o_busy` out 1: at least one response is in flight.

## Operation
- There is no ready signal on the request side. The responder accepts one request per cycle unconditionally, so full throughput is required.
- Address mapping:
  - `off = raddr - BASE_ADDR`, computed in 39 bits.
  - In range when `raddr >= BASE_ADDR` and `off[38:3] < DEPTH_WORDS`.
  - Index is `off[IDX_W+2:3]`.
  - `raddr[2:0]` is ignored; selecting the halfword within the word is the fetch unit's job.
- Out-of-range request: the response still occurs at the normal latency, with `rdata = 0` and `error = 1`. The store is not read.
- Store is synchronous single-read, single-write RAM, inferable as block RAM. It has no reset; contents survive `i_rst`.
- Load/read collision on the same index in the same cycle is read-before-write: the read returns the old data.
- In-flight tracking is a LATENCY-deep shift register of {valid, error} bits, parallel to the RAM read pipeline.
  - Stage 0 is written from `i_imem_ren` and the range check.
  - The last stage drives the outputs.
- Flush behaviour:
  - When `i_flush` is high, every in-flight valid bit is cleared at that edge.
  - A request sampled in the same cycle as `i_flush` is kept, because it is the post-redirect fetch.
  - A response presented on the outputs in the flush cycle is still delivered.
- Outputs are forced to 0 when not valid: `o_imem_rdata` and `o_imem_error` are 0 whenever `o_imem_valid` is 0.
- `o_busy` is the OR of all in-flight valid bits, including the output stage.

## Timing
- Reset: with `i_rst` high at an edge, all pipeline valid bits clear. After that edge, `o_imem_valid`, `o_imem_error` and `o_busy` are 0 and `o_imem_rdata` is 64'h0.
  - A request present during the reset cycle is dropped.
  - A load present during the reset cycle is still performed.
- Latency: a request sampled at edge N produces `o_imem_valid = 1` after edge N+LATENCY−1, visible in cycle N+LATENCY.
  - With LATENCY=1 the response is visible in the cycle after the request.
  - The registered RAM output is the final stage.
- Ordering: responses are strictly in request order. A request on every cycle gives a response on every cycle.
- Load then read of the same index: when a load at edge N is followed by a request at edge N+1, the read returns the new data.
- Flush timing: a flush at edge F suppresses every response from requests sampled before F that would otherwise appear after F. The response already visible in cycle F is delivered.
- Reset mid-stream: behaves as a flush that also drops the same-cycle request.

## Test plan
- Latency/throughput, LATENCY=2: preload words 0..3 with 64'hA0..A3, then issue `ren` for 4 consecutive cycles at BASE_ADDR+0,+8,+16,+24.
  - Required: valid high for exactly 4 consecutive cycles starting 2 cycles after the first request.
  - Required: rdata A0,A1,A2,A3 in order, error 0 throughout.
- Alignment: read BASE_ADDR+6 with word 0 = 64'h1122334455667788 -> rdata 64'h1122334455667788.
- Range check: read BASE_ADDR−8, then BASE_ADDR+8·DEPTH_WORDS, then BASE_ADDR+8·(DEPTH_WORDS−1).
  - Required: the first two return valid=1, error=1, rdata=0.
  - Required: the third returns error=0 with the stored word.
- Flush, LATENCY=3: requests at cycles 0,1,2, `i_flush` together with a new request at cycle 3.
  - Required: the response for cycle 0 appears in cycle 3.
  - Required: the responses for cycles 1 and 2 never appear.
  - Required: the response for cycle 3 appears in cycle 6; `o_busy` is 0 in cycles 4 and 5 apart from the cycle-3 request's own in-flight bit.
- Collision: load idx 5 = 64'hBEEF and read idx 5 in the same cycle -> returns the old value; a repeat read the next cycle -> returns 64'hBEEF.
- Reset mid-stream: with 2 responses in flight, assert `i_rst` for 1 cycle.
  - Required: no valid pulses follow and `o_busy` is 0.
  - Required: a subsequent read returns the pre-reset store contents.
